// File: rtl/calc7_pkg.sv
// Shared calc7 datapath constants, FSM encoding and BCD helpers.
// Used by the binary/BCD converters and the display driver.
package calc7_pkg;

    localparam int MAG_W      = 17;
    localparam int DIGITS     = 5;
    localparam int BCD_W      = 21;
    localparam int ACC_DIGITS = 6;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int CNT_W      = 5;

    localparam logic [4*DIGITS-1:0] BCD_MAX = 20'h99999;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Returns {ovf, five BCD digits}; a nonzero sixth digit saturates.
    function automatic logic [BCD_W-1:0] sat_digits(
        input logic [ACC_W-1:0] acc
    );
        logic o;
        o = |acc[ACC_W-1 -: 4];
        return {o, o ? BCD_MAX : acc[4*DIGITS-1:0]};
    endfunction

endpackage

// File: rtl/bin2bcd2_bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd2.sv
// Sequential sign-magnitude binary to signed BCD converter.
// One magnitude bit per clock, start/busy/done handshake.
module bin2bcd2
    import calc7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAG_W:0]   bin,
    output logic [BCD_W-1:0] BCD,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    state_t             state;
    logic [MAG_W-1:0]   sr;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               sign;

    logic [ACC_W-1:0]   acc_fix;
    logic [ACC_W-1:0]   acc_nxt;
    logic [MAG_W-1:0]   sr_nxt;
    logic [BCD_W-1:0]   res;
    logic               res_sign;
    logic               last;

    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_fix
        bcd_add3 u_add3 (
            .digit (acc[4*g +: 4]),
            .fixed (acc_fix[4*g +: 4])
        );
    end

    assign acc_nxt  = {acc_fix[ACC_W-2:0], sr[MAG_W-1]};
    assign sr_nxt   = {sr[MAG_W-2:0], 1'b0};
    assign res      = sat_digits(acc_nxt);
    // A zero magnitude is never reported as negative.
    assign res_sign = sign & (|acc_nxt);
    assign last     = (cnt == CNT_W'(MAG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            BCD   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= bin[MAG_W-1:0];
                        sign  <= bin[MAG_W];
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    sr  <= sr_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        BCD   <= {res_sign, res[4*DIGITS-1:0]};
                        ovf   <= res[BCD_W-1];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
